// File: rtl/pipe_stage_reg_if.sv
// Handshake/bus bundle between a pipeline stage and its inter-stage register.
// Master drives the upstream fields and controls; slave (the register) drives the out_* fields.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned TNEW_W = 2,
    parameter int unsigned EXC_W  = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              en;
    logic              flush;
    logic              req;
    logic              in_valid;
    logic [DATA_W-1:0] in_payload;
    logic [31:0]       in_pc;
    logic              in_bd;
    logic [TNEW_W-1:0] in_tnew;
    logic              in_wr_en;
    logic [4:0]        in_wr_addr;
    logic [EXC_W-1:0]  in_exc;
    logic [EXC_W-1:0]  new_exc;

    logic              out_valid;
    logic [DATA_W-1:0] out_payload;
    logic [31:0]       out_pc;
    logic              out_bd;
    logic [TNEW_W-1:0] out_tnew;
    logic              out_wr_en;
    logic [4:0]        out_wr_addr;
    logic [EXC_W-1:0]  out_exc;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output en, flush, req, in_valid, in_payload, in_pc, in_bd, in_tnew,
               in_wr_en, in_wr_addr, in_exc, new_exc,
        input  out_valid, out_payload, out_pc, out_bd, out_tnew, out_wr_en,
               out_wr_addr, out_exc, bubble_cnt
    );

    modport slave (
        input  en, flush, req, in_valid, in_payload, in_pc, in_bd, in_tnew,
               in_wr_en, in_wr_addr, in_exc, new_exc,
        output out_valid, out_payload, out_pc, out_bd, out_tnew, out_wr_en,
               out_wr_addr, out_exc, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic MIPS inter-stage pipeline register with stall, bubble, exception flush,
// stage-local exception merge and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned TNEW_W   = 2,
    parameter int unsigned TNEW_DEC = 1,
    parameter int unsigned EXC_W    = 5,
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] REQ_PC   = 32'h0000_4180
) (
    input logic             clk,
    input logic             reset,
    pipe_stage_reg_if.slave bus
);
    localparam logic [TNEW_W-1:0] TNEW_DEC_V = TNEW_W'(TNEW_DEC);

    logic [TNEW_W-1:0] tnew_c;
    logic [EXC_W-1:0]  exc_c;
    logic              wr_en_c;

    // Saturating T_new decrement; older exception wins; bubbles carry no exception.
    always_comb begin
        tnew_c  = '0;
        exc_c   = '0;
        wr_en_c = 1'b0;
        if (bus.in_tnew > TNEW_DEC_V) begin
            tnew_c = bus.in_tnew - TNEW_DEC_V;
        end
        if (bus.in_valid) begin
            exc_c = (bus.in_exc != '0) ? bus.in_exc : bus.new_exc;
        end
        wr_en_c = bus.in_wr_en & bus.in_valid & (bus.in_wr_addr != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid   <= 1'b0;
            bus.out_payload <= '0;
            bus.out_pc      <= 32'd0;
            bus.out_bd      <= 1'b0;
            bus.out_tnew    <= '0;
            bus.out_wr_en   <= 1'b0;
            bus.out_wr_addr <= 5'd0;
            bus.out_exc     <= '0;
            bus.bubble_cnt  <= '0;
        end else if (bus.req) begin
            bus.out_valid   <= 1'b0;
            bus.out_payload <= '0;
            bus.out_pc      <= REQ_PC;
            bus.out_bd      <= 1'b0;
            bus.out_tnew    <= '0;
            bus.out_wr_en   <= 1'b0;
            bus.out_wr_addr <= 5'd0;
            bus.out_exc     <= '0;
        end else if (bus.flush) begin
            // Bubble keeps PC/BD so EPC is still right when it reaches M.
            bus.out_valid   <= 1'b0;
            bus.out_payload <= '0;
            bus.out_pc      <= bus.in_pc;
            bus.out_bd      <= bus.in_bd;
            bus.out_tnew    <= '0;
            bus.out_wr_en   <= 1'b0;
            bus.out_wr_addr <= 5'd0;
            bus.out_exc     <= '0;
            if (bus.bubble_cnt != '1) begin
                bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
            end
        end else if (bus.en) begin
            bus.out_valid   <= bus.in_valid;
            bus.out_payload <= bus.in_payload;
            bus.out_pc      <= bus.in_pc;
            bus.out_bd      <= bus.in_bd;
            bus.out_tnew    <= tnew_c;
            bus.out_wr_en   <= wr_en_c;
            bus.out_wr_addr <= bus.in_wr_addr;
            bus.out_exc     <= exc_c;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench: default instance, a TNEW_DEC=0 instance and a CNT_W=2
// instance, all driven by the same stimulus.
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic         en, flush, req, in_valid, in_bd, in_wr_en;
    logic [127:0] in_payload;
    logic [31:0]  in_pc;
    logic [1:0]   in_tnew;
    logic [4:0]   in_wr_addr;
    logic [4:0]   in_exc, new_exc;

    pipe_stage_reg_if #(.CNT_W(16)) i0 ();
    pipe_stage_reg_if #(.CNT_W(16)) i1 ();
    pipe_stage_reg_if #(.CNT_W(2))  i2 ();

    pipe_stage_reg dut0 (.clk(clk), .reset(reset), .bus(i0));
    pipe_stage_reg #(.TNEW_DEC(0)) dut1 (.clk(clk), .reset(reset), .bus(i1));
    pipe_stage_reg #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(i2));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        i0.en = en; i0.flush = flush; i0.req = req; i0.in_valid = in_valid;
        i0.in_payload = in_payload; i0.in_pc = in_pc; i0.in_bd = in_bd; i0.in_tnew = in_tnew;
        i0.in_wr_en = in_wr_en; i0.in_wr_addr = in_wr_addr; i0.in_exc = in_exc; i0.new_exc = new_exc;
        i1.en = en; i1.flush = flush; i1.req = req; i1.in_valid = in_valid;
        i1.in_payload = in_payload; i1.in_pc = in_pc; i1.in_bd = in_bd; i1.in_tnew = in_tnew;
        i1.in_wr_en = in_wr_en; i1.in_wr_addr = in_wr_addr; i1.in_exc = in_exc; i1.new_exc = new_exc;
        i2.en = en; i2.flush = flush; i2.req = req; i2.in_valid = in_valid;
        i2.in_payload = in_payload; i2.in_pc = in_pc; i2.in_bd = in_bd; i2.in_tnew = in_tnew;
        i2.in_wr_en = in_wr_en; i2.in_wr_addr = in_wr_addr; i2.in_exc = in_exc; i2.new_exc = new_exc;
    endtask

    task automatic step();
        apply();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0; req = 1'b0; in_valid = 1'b0;
        in_payload = '0; in_pc = '0; in_bd = 1'b0; in_tnew = '0; in_wr_en = 1'b0;
        in_wr_addr = '0; in_exc = '0; new_exc = '0;
        step();
        step();
        chk("rst_valid", 128'(i0.out_valid), 128'(0));
        chk("rst_pc", 128'(i0.out_pc), 128'(0));
        chk("rst_tnew", 128'(i0.out_tnew), 128'(0));
        chk("rst_payload", i0.out_payload, 128'(0));
        chk("rst_cnt", 128'(i0.bubble_cnt), 128'(0));

        // Basic load
        reset = 1'b0; en = 1'b1; in_valid = 1'b1; in_pc = 32'h3004; in_tnew = 2'd2;
        in_wr_addr = 5'd8; in_wr_en = 1'b1; in_payload = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        step();
        chk("ld_pc", 128'(i0.out_pc), 128'(32'h3004));
        chk("ld_tnew", 128'(i0.out_tnew), 128'(1));
        chk("ld_wr_en", 128'(i0.out_wr_en), 128'(1));
        chk("ld_wr_addr", 128'(i0.out_wr_addr), 128'(8));
        chk("ld_valid", 128'(i0.out_valid), 128'(1));
        chk("ld_payload", i0.out_payload, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
        chk("ld_tnew_dec0", 128'(i1.out_tnew), 128'(2));

        // T_new saturating decrement
        in_tnew = 2'd0; step();
        chk("tnew0", 128'(i0.out_tnew), 128'(0));
        in_tnew = 2'd1; step();
        chk("tnew1", 128'(i0.out_tnew), 128'(0));
        chk("tnew1_dec0", 128'(i1.out_tnew), 128'(1));
        in_tnew = 2'd3; step();
        chk("tnew3", 128'(i0.out_tnew), 128'(2));

        // Exception merge
        in_exc = 5'd0; new_exc = 5'd4; step();
        chk("exc_new", 128'(i0.out_exc), 128'(4));
        in_exc = 5'd10; new_exc = 5'd4; step();
        chk("exc_old", 128'(i0.out_exc), 128'(10));
        in_valid = 1'b0; step();
        chk("exc_invalid", 128'(i0.out_exc), 128'(0));
        chk("wr_en_invalid", 128'(i0.out_wr_en), 128'(0));
        chk("valid_invalid", 128'(i0.out_valid), 128'(0));

        // $0 write suppression
        in_valid = 1'b1; in_exc = 5'd0; new_exc = 5'd0; in_wr_en = 1'b1; in_wr_addr = 5'd0; step();
        chk("wr0_en", 128'(i0.out_wr_en), 128'(0));

        // Known state, then hold 3 cycles with changing inputs
        in_pc = 32'h3008; in_tnew = 2'd2; in_wr_addr = 5'd9; in_payload = 128'h1234; step();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_pc = 32'h5000 + 32'(k); in_payload = 128'(k + 100); in_tnew = 2'd3;
            in_wr_addr = 5'd20; in_valid = 1'b0;
            step();
            chk("hold_pc", 128'(i0.out_pc), 128'(32'h3008));
        end
        chk("hold_valid", 128'(i0.out_valid), 128'(1));
        chk("hold_payload", i0.out_payload, 128'h1234);
        chk("hold_tnew", 128'(i0.out_tnew), 128'(1));
        chk("hold_wr_en", 128'(i0.out_wr_en), 128'(1));
        chk("hold_wr_addr", 128'(i0.out_wr_addr), 128'(9));
        chk("hold_cnt", 128'(i0.bubble_cnt), 128'(0));

        // Flush with en=0: bubble keeps PC/BD
        flush = 1'b1; in_pc = 32'h3010; in_bd = 1'b1; in_valid = 1'b1; in_wr_en = 1'b1;
        in_wr_addr = 5'd7; step();
        chk("fl_valid", 128'(i0.out_valid), 128'(0));
        chk("fl_wr_en", 128'(i0.out_wr_en), 128'(0));
        chk("fl_pc", 128'(i0.out_pc), 128'(32'h3010));
        chk("fl_bd", 128'(i0.out_bd), 128'(1));
        chk("fl_payload", i0.out_payload, 128'(0));
        chk("fl_cnt", 128'(i0.bubble_cnt), 128'(1));

        // req beats flush and en
        req = 1'b1; en = 1'b1; step();
        chk("rq_pc", 128'(i0.out_pc), 128'(32'h4180));
        chk("rq_valid", 128'(i0.out_valid), 128'(0));
        chk("rq_bd", 128'(i0.out_bd), 128'(0));
        chk("rq_wr_addr", 128'(i0.out_wr_addr), 128'(0));
        chk("rq_exc", 128'(i0.out_exc), 128'(0));
        chk("rq_cnt", 128'(i0.bubble_cnt), 128'(1));

        // Four more flushes: 5 total; CNT_W=2 saturates at 3
        req = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("sat_cnt2", 128'(i2.bubble_cnt), 128'(3));
        chk("cnt16", 128'(i0.bubble_cnt), 128'(5));

        // Reset wins over flush
        reset = 1'b1; step();
        chk("rf_cnt", 128'(i2.bubble_cnt), 128'(0));
        chk("rf_cnt16", 128'(i0.bubble_cnt), 128'(0));
        chk("rf_pc", 128'(i0.out_pc), 128'(0));
        chk("rf_bd", 128'(i0.out_bd), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
